// File: rtl/alu_shift_seq_pkg.sv
// Shared CPU definitions used by the shift sequencer: ALU opcodes for the
// fixed-step shifts and the sequencer state encoding.
package cpuv2_pkg;

  localparam logic [3:0] ALU_SHL  = 4'd8;
  localparam logic [3:0] ALU_SHR  = 4'd9;
  localparam logic [3:0] ALU_SL4  = 4'd12;
  localparam logic [3:0] ALU_SL16 = 4'd13;
  localparam logic [3:0] ALU_SR4  = 4'd14;
  localparam logic [3:0] ALU_SR16 = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_shift_seq_if.sv
// Request/response bus of the shift sequencer. The master issues shift
// requests and consumes results; the slave is the sequencer itself.
interface alu_shift_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_value;
  logic [4:0]  req_amount;
  logic        req_dir;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_z;
  logic        rsp_c;
  logic        rsp_n;

  modport master (
    output req_valid, req_value, req_amount, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_z, rsp_c, rsp_n
  );

  modport slave (
    input  req_valid, req_value, req_amount, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_z, rsp_c, rsp_n
  );
endinterface

// File: rtl/alu_shift_seq_step.sv
// Step decoder: picks the largest enabled fixed-step shift that does not
// overshoot the remaining distance and returns the distance left after it.
module alu_shift_step
  import cpuv2_pkg::*;
#(
  parameter int unsigned USE_SL16 = 1,
  parameter int unsigned USE_SL4  = 1
) (
  input  logic [4:0] r_i,
  input  logic       dir_i,
  output logic [3:0] op_o,
  output logic [4:0] r_next_o
);

  // Greedy choice: 16, then 4, then 1; disabled step sizes are skipped.
  always_comb begin
    op_o     = dir_i ? ALU_SHR : ALU_SHL;
    r_next_o = r_i - 5'd1;
    if ((USE_SL16 != 0) && (r_i >= 5'd16)) begin
      op_o     = dir_i ? ALU_SR16 : ALU_SL16;
      r_next_o = r_i - 5'd16;
    end else if ((USE_SL4 != 0) && (r_i >= 5'd4)) begin
      op_o     = dir_i ? ALU_SR4 : ALU_SL4;
      r_next_o = r_i - 5'd4;
    end
  end

endmodule

// File: rtl/alu_shift_seq.sv
// Variable-distance logical shifter built on the shared ALU's fixed-step
// shift ops. While running it owns the ALU inputs (alu_sel=1), feeding the
// working value back through the ALU one step per cycle.
module alu_shift_seq
  import cpuv2_pkg::*;
#(
  parameter int unsigned USE_SL16 = 1,
  parameter int unsigned USE_SL4  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_shift_seq_if.slave   bus,
  output logic             alu_sel,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_a,
  input  logic [31:0]      alu_result,
  input  logic             alu_c
);

  state_t      state_q;
  logic [4:0]  r_q;      // distance still to go after the op in op_q
  logic        dir_q;
  logic        sel_q;
  logic [3:0]  op_q;
  logic [31:0] w_q;      // working value presented to the ALU
  logic        ready_q;
  logic        vld_q;
  logic [31:0] res_q;
  logic        z_q;
  logic        c_q;
  logic        n_q;

  logic [4:0]  step_r;
  logic        step_dir;
  logic [3:0]  step_op;
  logic [4:0]  step_r_next;

  // While idle the decoder plans the first step of the incoming request;
  // while running it plans the step after the one being issued.
  assign step_r   = (state_q == ST_IDLE) ? bus.req_amount : r_q;
  assign step_dir = (state_q == ST_IDLE) ? bus.req_dir    : dir_q;

  alu_shift_step #(
    .USE_SL16 (USE_SL16),
    .USE_SL4  (USE_SL4)
  ) u_step (
    .r_i      (step_r),
    .dir_i    (step_dir),
    .op_o     (step_op),
    .r_next_o (step_r_next)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= 5'd0;
      dir_q   <= 1'b0;
      sel_q   <= 1'b0;
      op_q    <= 4'd0;
      w_q     <= 32'd0;
      ready_q <= 1'b1;
      vld_q   <= 1'b0;
      res_q   <= 32'd0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            dir_q   <= bus.req_dir;
            if (bus.req_amount == 5'd0) begin
              // Zero distance: result is the operand, no ALU op issued.
              state_q <= ST_DONE;
              vld_q   <= 1'b1;
              res_q   <= bus.req_value;
              z_q     <= (bus.req_value == 32'd0);
              n_q     <= bus.req_value[31];
              c_q     <= 1'b0;
            end else begin
              state_q <= ST_RUN;
              sel_q   <= 1'b1;
              w_q     <= bus.req_value;
              op_q    <= step_op;
              r_q     <= step_r_next;
            end
          end
        end
        ST_RUN: begin
          if (r_q == 5'd0) begin
            // Last step: capture result and carry, release the ALU.
            state_q <= ST_DONE;
            sel_q   <= 1'b0;
            vld_q   <= 1'b1;
            res_q   <= alu_result;
            z_q     <= (alu_result == 32'd0);
            n_q     <= alu_result[31];
            c_q     <= alu_c;
          end else begin
            w_q  <= alu_result;
            op_q <= step_op;
            r_q  <= step_r_next;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          sel_q   <= 1'b0;
          vld_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign alu_sel        = sel_q;
  assign alu_op         = op_q;
  assign alu_a          = w_q;
  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_c      = c_q;
  assign bus.rsp_n      = n_q;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: two instances (all steps enabled / single-bit
// steps only), each with its own ALU behind a core-style alu_sel mux.
module tb_alu_shift_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg = 1'b0;  // 0: instance with 16/4 steps, 1: single-step instance
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic [31:0] req_value = 32'd0;
  logic [4:0]  req_amount = 5'd0;
  logic        req_dir = 1'b0;
  logic        rsp_ready = 1'b0;

  alu_shift_seq_if ifa ();
  alu_shift_seq_if ifb ();

  assign ifa.req_valid  = req_valid & ~cfg;
  assign ifa.req_value  = req_value;
  assign ifa.req_amount = req_amount;
  assign ifa.req_dir    = req_dir;
  assign ifa.rsp_ready  = rsp_ready & ~cfg;
  assign ifb.req_valid  = req_valid & cfg;
  assign ifb.req_value  = req_value;
  assign ifb.req_amount = req_amount;
  assign ifb.req_dir    = req_dir;
  assign ifb.rsp_ready  = rsp_ready & cfg;

  logic        sel_a, sel_b, c_a, c_b;
  logic [3:0]  op_a, op_b;
  logic [31:0] a_a, a_b, res_a, res_b;

  // Reference ALU: only the shift ops matter; others pass arg_a through.
  function automatic logic [32:0] alu_f(input logic [3:0] op, input logic [31:0] a);
    case (op)
      4'd8:    return {a[31], a << 1};
      4'd9:    return {a[0],  a >> 1};
      4'd12:   return {a[28], a << 4};
      4'd13:   return {a[16], a << 16};
      4'd14:   return {a[3],  a >> 4};
      4'd15:   return {a[15], a >> 16};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {c_a, res_a} = alu_f(sel_a ? op_a : 4'd0, sel_a ? a_a : 32'hDEAD_BEEF);
  assign {c_b, res_b} = alu_f(sel_b ? op_b : 4'd0, sel_b ? a_b : 32'hDEAD_BEEF);

  alu_shift_seq #(.USE_SL16(1), .USE_SL4(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .alu_sel(sel_a), .alu_op(op_a), .alu_a(a_a),
    .alu_result(res_a), .alu_c(c_a)
  );

  alu_shift_seq #(.USE_SL16(0), .USE_SL4(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .alu_sel(sel_b), .alu_op(op_b), .alu_a(a_b),
    .alu_result(res_b), .alu_c(c_b)
  );

  logic        rdy_m, vld_m, sel_m, z_m, c_m, n_m;
  logic [3:0]  op_m;
  logic [31:0] a_m, res_m;
  assign rdy_m = cfg ? ifb.req_ready  : ifa.req_ready;
  assign vld_m = cfg ? ifb.rsp_valid  : ifa.rsp_valid;
  assign res_m = cfg ? ifb.rsp_result : ifa.rsp_result;
  assign z_m   = cfg ? ifb.rsp_z      : ifa.rsp_z;
  assign c_m   = cfg ? ifb.rsp_c      : ifa.rsp_c;
  assign n_m   = cfg ? ifb.rsp_n      : ifa.rsp_n;
  assign sel_m = cfg ? sel_b : sel_a;
  assign op_m  = cfg ? op_b  : op_a;
  assign a_m   = cfg ? a_b   : a_a;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_rdy = 1'b1, m_vld = 1'b0, m_sel = 1'b0;
  logic        m_z = 1'b0, m_c = 1'b0, m_n = 1'b0, m_dir = 1'b0;
  logic [3:0]  m_op = 4'd0;
  logic [31:0] m_a = 32'd0, m_res = 32'd0, m_val = 32'd0;
  int          m_amt = 0, m_done = 0, m_r = 0;
  int          m_steps[$];
  bit          started = 1'b0;
  logic [3:0]  op_log[$];

  function automatic logic [31:0] shv(input logic [31:0] v, input int n, input logic d);
    return d ? (v >> n) : (v << n);
  endfunction

  function automatic logic [3:0] opof(input int s, input logic d);
    if (s == 16) return d ? 4'd15 : 4'd13;
    if (s == 4)  return d ? 4'd14 : 4'd12;
    return d ? 4'd9 : 4'd8;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rdy = 1'b1; m_vld = 1'b0; m_sel = 1'b0; m_op = 4'd0; m_a = 32'd0;
      m_res = 32'd0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
      m_steps.delete();
      started = 1'b1;
    end else if (m_rdy) begin
      if (req_valid) begin
        m_rdy = 1'b0;
        m_val = req_value;
        m_dir = req_dir;
        m_amt = int'(req_amount);
        m_res = shv(req_value, m_amt, req_dir);
        m_c   = (m_amt == 0) ? 1'b0 : (req_dir ? req_value[m_amt-1] : req_value[32-m_amt]);
        m_z   = (m_res == 32'd0);
        m_n   = m_res[31];
        m_steps.delete();
        m_r = m_amt;
        while (m_r > 0) begin
          if (!cfg && m_r >= 16)     begin m_steps.push_back(16); m_r -= 16; end
          else if (!cfg && m_r >= 4) begin m_steps.push_back(4);  m_r -= 4;  end
          else                       begin m_steps.push_back(1);  m_r -= 1;  end
        end
        if (m_amt == 0) m_vld = 1'b1;
        else begin
          m_sel = 1'b1; m_done = 0; m_a = req_value; m_op = opof(m_steps[0], req_dir);
        end
      end
    end else if (m_sel) begin
      m_done += m_steps.pop_front();
      if (m_steps.size() == 0) begin
        m_sel = 1'b0; m_vld = 1'b1;
      end else begin
        m_a  = shv(m_val, m_done, m_dir);
        m_op = opof(m_steps[0], m_dir);
      end
    end else if (m_vld && rsp_ready) begin
      m_vld = 1'b0; m_rdy = 1'b1;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", 32'(rdy_m), 32'(m_rdy));
      chk("rsp_valid", 32'(vld_m), 32'(m_vld));
      chk("alu_sel",   32'(sel_m), 32'(m_sel));
      chk("alu_op",    32'(op_m),  32'(m_op));
      chk("alu_a",     a_m,        m_a);
      if (m_vld) begin
        chk("rsp_result", res_m,      m_res);
        chk("rsp_z",      32'(z_m),   32'(m_z));
        chk("rsp_c",      32'(c_m),   32'(m_c));
        chk("rsp_n",      32'(n_m),   32'(m_n));
      end
      if (sel_m === 1'b1) op_log.push_back(op_m);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic [31:0] v, input logic [4:0] a, input logic d, output int lat);
    int cyc;
    @(negedge clk);
    op_log.delete();
    req_valid = 1'b1; req_value = v; req_amount = a; req_dir = d; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_value = $urandom; req_amount = 5'($urandom); req_dir = 1'($urandom);
    cyc = 1;
    while (vld_m !== 1'b1 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (vld_m !== 1'b1) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: got no rsp_valid after %0d cycles, required one", cyc);
    end
    lat = cyc;
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] pack_ops();
    logic [31:0] pk;
    int n9;
    pk = 32'd0;
    foreach (op_log[i]) pk = {pk[27:0], op_log[i]};
    return pk;
  endfunction

  function automatic int count_op(input logic [3:0] op);
    int n;
    n = 0;
    foreach (op_log[i]) if (op_log[i] == op) n++;
    return n;
  endfunction

  initial begin
    int lat;
    logic [31:0] v;
    logic [4:0]  a;
    logic        d;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk); #1;
    chk("reset_req_ready", 32'(rdy_m), 32'd1);
    chk("reset_rsp_valid", 32'(vld_m), 32'd0);
    chk("reset_alu_sel",   32'(sel_m), 32'd0);
    chk("reset_alu_op",    32'(op_m),  32'd0);
    chk("reset_alu_a",     a_m,        32'd0);
    chk("reset_rsp_result", res_m,     32'd0);

    // 1: 1 << 31 via 16,4,4,4,1,1,1
    do_req(32'h0000_0001, 5'd31, 1'b0, lat);
    chk("t1_latency", 32'(lat), 32'd8);
    chk("t1_result", res_m, 32'h8000_0000);
    chk("t1_c", 32'(c_m), 32'd0);
    chk("t1_n", 32'(n_m), 32'd1);
    chk("t1_z", 32'(z_m), 32'd0);
    chk("t1_nops", 32'(op_log.size()), 32'd7);
    chk("t1_ops", pack_ops(), 32'h0DCC_C888);
    finish_rsp();

    // 2: single right shift, response held under back-pressure
    do_req(32'h8000_0001, 5'd1, 1'b1, lat);
    chk("t2_latency", 32'(lat), 32'd2);
    chk("t2_ops", pack_ops(), 32'h0000_0009);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t2_hold_valid",  32'(vld_m), 32'd1);
      chk("t2_hold_result", res_m, 32'h4000_0000);
      chk("t2_hold_c",      32'(c_m), 32'd1);
    end
    finish_rsp();

    // 3: zero distance
    do_req(32'h1234_5678, 5'd0, 1'b0, lat);
    chk("t3_latency", 32'(lat), 32'd1);
    chk("t3_result", res_m, 32'h1234_5678);
    chk("t3_c", 32'(c_m), 32'd0);
    chk("t3_nops", 32'(op_log.size()), 32'd0);
    finish_rsp();

    // 4: one 16-step, everything shifted out
    do_req(32'hFFFF_0000, 5'd16, 1'b0, lat);
    chk("t4_latency", 32'(lat), 32'd2);
    chk("t4_result", res_m, 32'h0000_0000);
    chk("t4_z", 32'(z_m), 32'd1);
    chk("t4_c", 32'(c_m), 32'd1);
    chk("t4_ops", pack_ops(), 32'h0000_000D);
    finish_rsp();

    // 5: reset during the third step of test 1
    @(negedge clk);
    op_log.delete();
    req_valid = 1'b1; req_value = 32'h0000_0001; req_amount = 5'd31; req_dir = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 20 && op_log.size() < 3; k++) begin
      @(negedge clk); #1;
    end
    chk("t5_reached_step3", 32'(op_log.size()), 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("t5_no_rsp_valid", 32'(vld_m), 32'd0);
      chk("t5_idle_ready",   32'(rdy_m), 32'd1);
    end
    do_req(32'h0000_00F0, 5'd4, 1'b1, lat);
    chk("t5_after_latency", 32'(lat), 32'd2);
    chk("t5_after_result", res_m, 32'h0000_000F);
    chk("t5_after_c", 32'(c_m), 32'd0);
    chk("t5_after_ops", pack_ops(), 32'h0000_000E);
    finish_rsp();

    // random requests, all step sizes enabled
    for (int i = 0; i < 20; i++) begin
      v = $urandom; a = 5'($urandom); d = 1'($urandom);
      do_req(v, a, d, lat);
      chk("randA_result", res_m, d ? (v >> a) : (v << a));
      finish_rsp();
    end

    // switch to the single-step instance under reset
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 cfg = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    // 6: 20 single-bit right shifts
    do_req(32'hA5A5_A5A5, 5'd20, 1'b1, lat);
    chk("t6_latency", 32'(lat), 32'd21);
    chk("t6_result", res_m, 32'h0000_0A5A);
    chk("t6_c", 32'(c_m), 32'd0);
    chk("t6_nops", 32'(op_log.size()), 32'd20);
    chk("t6_all_shr", 32'(count_op(4'd9)), 32'd20);
    finish_rsp();

    for (int i = 0; i < 8; i++) begin
      v = $urandom; a = 5'($urandom); d = 1'($urandom);
      do_req(v, a, d, lat);
      chk("randB_result", res_m, d ? (v >> a) : (v << a));
      finish_rsp();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
